// File: rtl/collatz_pkg.sv
// rtl/collatz_pkg.sv - shared types and constants for the Collatz range tester
// Purpose: FSM state encodings for the top level and the iterator lanes, plus the
//          saturation value used for sequence lengths.
// Ports:   none (package).
package collatz_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        L_IDLE,
        L_ITER,
        L_HOLD
    } lane_state_t;

    localparam int COUNT_WIDTH_DEFAULT = 16;

    // All-ones value of a width-bit length counter.
    function automatic longint unsigned count_sat(input int width);
        return (longint'(1) << width) - 1;
    endfunction

    localparam longint unsigned COUNT_SAT = count_sat(COUNT_WIDTH_DEFAULT);

endpackage

// File: rtl/collatz_lane.sv
// rtl/collatz_lane.sv - single Collatz iterator lane, one step per clock
// Purpose: iterates n to 1 and counts terms; holds {tag, length} until granted.
// Ports:   clk, reset (async, active-high), clr (sync abort), go/n/tag (dispatch),
//          grant (result consumed); busy, result_valid, result_tag, result_len,
//          result_ovf (3n+1 did not fit in N_WIDTH).
module collatz_lane
    import collatz_pkg::*;
#(
    parameter int N_WIDTH     = 32,
    parameter int COUNT_WIDTH = 16,
    parameter int TAG_WIDTH   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   go,
    input  logic [N_WIDTH-1:0]     n,
    input  logic [TAG_WIDTH-1:0]   tag,
    input  logic                   grant,
    output logic                   busy,
    output logic                   result_valid,
    output logic [TAG_WIDTH-1:0]   result_tag,
    output logic [COUNT_WIDTH-1:0] result_len,
    output logic                   result_ovf
);

    localparam logic [COUNT_WIDTH-1:0] LEN_SAT = '1;

    lane_state_t            state, state_d;
    logic [N_WIDTH-1:0]     cur, cur_d;
    logic [COUNT_WIDTH-1:0] len, len_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic                   ovf, ovf_d;
    logic [N_WIDTH+1:0]     tripled;

    // 3n+1 with two guard bits so an overflow out of N_WIDTH is visible.
    assign tripled = {2'b00, cur} + {1'b0, cur, 1'b0} + (N_WIDTH+2)'(1);

    always_comb begin
        state_d = state;
        cur_d   = cur;
        len_d   = len;
        tag_d   = tag_q;
        ovf_d   = ovf;
        case (state)
            L_IDLE: begin
                if (go) begin
                    tag_d = tag;
                    cur_d = n;
                    ovf_d = 1'b0;
                    if (n == '0) begin
                        len_d   = '0;
                        state_d = L_HOLD;
                    end else begin
                        len_d   = COUNT_WIDTH'(1);
                        state_d = L_ITER;
                    end
                end
            end
            L_ITER: begin
                if (cur == N_WIDTH'(1)) begin
                    state_d = L_HOLD;
                end else if (len == LEN_SAT) begin
                    state_d = L_HOLD;
                end else if (cur[0] && (tripled[N_WIDTH+1:N_WIDTH] != 2'b00)) begin
                    len_d   = LEN_SAT;
                    ovf_d   = 1'b1;
                    state_d = L_HOLD;
                end else begin
                    cur_d = cur[0] ? tripled[N_WIDTH-1:0] : (cur >> 1);
                    len_d = len + COUNT_WIDTH'(1);
                end
            end
            L_HOLD: begin
                if (grant) state_d = L_IDLE;
            end
            default: state_d = L_IDLE;
        endcase
        if (clr) begin
            state_d = L_IDLE;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= L_IDLE;
            cur   <= '0;
            len   <= '0;
            tag_q <= '0;
            ovf   <= 1'b0;
        end else begin
            state <= state_d;
            cur   <= cur_d;
            len   <= len_d;
            tag_q <= tag_d;
            ovf   <= ovf_d;
        end
    end

    assign busy         = (state != L_IDLE);
    assign result_valid = (state == L_HOLD);
    assign result_tag   = tag_q;
    assign result_len   = len;
    assign result_ovf   = ovf;

endmodule

// File: rtl/collatz_range_multi.sv
// rtl/collatz_range_multi.sv - multi-lane Collatz range tester with result RAM
// Purpose: computes sequence lengths for start..start+RAM_WORDS-1 on LANES lanes.
// Ports:   clk, reset (async, active-high), go/start (begin or restart a run),
//          busy, done, overflow (sticky per run), rd_addr -> count (registered,
//          zero unless done).
module collatz_range_multi
    import collatz_pkg::*;
#(
    parameter int N_WIDTH       = 32,
    parameter int COUNT_WIDTH   = 16,
    parameter int RAM_WORDS     = 16,
    parameter int RAM_ADDR_BITS = 4,
    parameter int LANES         = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     go,
    input  logic [N_WIDTH-1:0]       start,
    output logic                     busy,
    output logic                     done,
    output logic                     overflow,
    input  logic [RAM_ADDR_BITS-1:0] rd_addr,
    output logic [COUNT_WIDTH-1:0]   count
);

    // One extra bit so the index/counters can hold RAM_WORDS itself.
    localparam int                IDX_W = RAM_ADDR_BITS + 1;
    localparam logic [IDX_W-1:0] WORDS = IDX_W'(RAM_WORDS);

    state_t                   state, state_d;
    logic [N_WIDTH-1:0]       base;
    logic [IDX_W-1:0]         idx;
    logic [IDX_W-1:0]         written;

    logic [LANES-1:0]         lane_go, lane_grant, lane_busy, lane_valid, lane_ovf;
    logic [RAM_ADDR_BITS-1:0] lane_tag [LANES];
    logic [COUNT_WIDTH-1:0]   lane_len [LANES];

    logic                     disp_en, disp_found;
    logic [N_WIDTH-1:0]       disp_value;
    logic [RAM_ADDR_BITS-1:0] disp_tag;

    logic                     wr_en, wr_ovf;
    logic [RAM_ADDR_BITS-1:0] wr_tag;
    logic [COUNT_WIDTH-1:0]   wr_len;

    logic [COUNT_WIDTH-1:0]   mem [2**RAM_ADDR_BITS];

    assign disp_value = base + N_WIDTH'(idx);
    assign disp_tag   = idx[RAM_ADDR_BITS-1:0];

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        collatz_lane #(
            .N_WIDTH    (N_WIDTH),
            .COUNT_WIDTH(COUNT_WIDTH),
            .TAG_WIDTH  (RAM_ADDR_BITS)
        ) u_lane (
            .clk         (clk),
            .reset       (reset),
            .clr         (go),
            .go          (lane_go[g]),
            .n           (disp_value),
            .tag         (disp_tag),
            .grant       (lane_grant[g]),
            .busy        (lane_busy[g]),
            .result_valid(lane_valid[g]),
            .result_tag  (lane_tag[g]),
            .result_len  (lane_len[g]),
            .result_ovf  (lane_ovf[g])
        );
    end

    // Dispatch to the lowest idle lane; a go cycle dispatches nothing.
    always_comb begin
        lane_go    = '0;
        disp_found = 1'b0;
        if (state == S_RUN && !go && idx != WORDS) begin
            for (int i = 0; i < LANES; i++) begin
                if (!disp_found && !lane_busy[i]) begin
                    lane_go[i] = 1'b1;
                    disp_found = 1'b1;
                end
            end
        end
    end
    assign disp_en = disp_found;

    // One RAM write per cycle, lowest lane wins; others keep holding.
    always_comb begin
        lane_grant = '0;
        wr_en      = 1'b0;
        wr_tag     = '0;
        wr_len     = '0;
        wr_ovf     = 1'b0;
        if (state == S_RUN && !go) begin
            for (int i = 0; i < LANES; i++) begin
                if (!wr_en && lane_valid[i]) begin
                    lane_grant[i] = 1'b1;
                    wr_en         = 1'b1;
                    wr_tag        = lane_tag[i];
                    wr_len        = lane_len[i];
                    wr_ovf        = lane_ovf[i];
                end
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  state_d = S_IDLE;
            S_RUN:   if (written == WORDS && lane_busy == '0) state_d = S_DONE;
            S_DONE:  state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
        if (go) state_d = S_RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            base     <= '0;
            idx      <= '0;
            written  <= '0;
            overflow <= 1'b0;
            count    <= '0;
        end else begin
            state <= state_d;
            if (go) begin
                base     <= start;
                idx      <= '0;
                written  <= '0;
                overflow <= 1'b0;
            end else begin
                if (disp_en) idx <= idx + IDX_W'(1);
                if (wr_en) begin
                    written <= written + IDX_W'(1);
                    if (wr_ovf) overflow <= 1'b1;
                end
            end
            // Gate on next state so count is already zero in the cycle done drops.
            if (state_d == S_DONE && ({1'b0, rd_addr} < WORDS))
                count <= mem[rd_addr];
            else
                count <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_tag] <= wr_len;
    end

    assign busy = (state == S_RUN);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_collatz_range_multi.sv
// tb/tb_collatz_range_multi.sv - self-checking bench for collatz_range_multi
module tb_collatz_range_multi;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    // a: defaults (4 lanes), b: 1 lane, c: 8-bit datapath, d: 6-bit lengths
    logic        go_a = 0, go_b = 0, go_c = 0, go_d = 0;
    logic [31:0] start_a = 0, start_b = 0, start_d = 0;
    logic [7:0]  start_c = 0;
    logic [3:0]  rd_a = 0, rd_b = 0;
    logic        rd_c = 0, rd_d = 0;
    logic        busy_a, busy_b, busy_c, busy_d;
    logic        done_a, done_b, done_c, done_d;
    logic        ovf_a, ovf_b, ovf_c, ovf_d;
    logic [15:0] count_a, count_b, count_c;
    logic [5:0]  count_d;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_tab [16] = '{1, 2, 8, 3, 6, 9, 17, 4, 20, 7, 15, 10, 10, 18, 18, 5};

    collatz_range_multi dut_a (
        .clk(clk), .reset(reset), .go(go_a), .start(start_a), .busy(busy_a),
        .done(done_a), .overflow(ovf_a), .rd_addr(rd_a), .count(count_a));

    collatz_range_multi #(.LANES(1)) dut_b (
        .clk(clk), .reset(reset), .go(go_b), .start(start_b), .busy(busy_b),
        .done(done_b), .overflow(ovf_b), .rd_addr(rd_b), .count(count_b));

    collatz_range_multi #(.N_WIDTH(8), .RAM_WORDS(1), .RAM_ADDR_BITS(1), .LANES(1)) dut_c (
        .clk(clk), .reset(reset), .go(go_c), .start(start_c), .busy(busy_c),
        .done(done_c), .overflow(ovf_c), .rd_addr(rd_c), .count(count_c));

    collatz_range_multi #(.COUNT_WIDTH(6), .RAM_WORDS(1), .RAM_ADDR_BITS(1), .LANES(1)) dut_d (
        .clk(clk), .reset(reset), .go(go_d), .start(start_d), .busy(busy_d),
        .done(done_d), .overflow(ovf_d), .rd_addr(rd_d), .count(count_d));

    task automatic wait_done(input int which, input int budget, output int cycles);
        logic d;
        cycles = -1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            case (which)
                0: d = done_a;
                1: d = done_b;
                2: d = done_c;
                default: d = done_d;
            endcase
            if (d) begin
                cycles = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy_a, busy_b, busy_c, busy_d} !== 4'b0) begin
            n_fail++; $display("FAIL reset_busy got %b want 0000", {busy_a, busy_b, busy_c, busy_d});
        end
        n_checks++;
        if ({done_a, done_b, done_c, done_d} !== 4'b0) begin
            n_fail++; $display("FAIL reset_done got %b want 0000", {done_a, done_b, done_c, done_d});
        end
        n_checks++;
        if ({ovf_a, ovf_b, ovf_c, ovf_d} !== 4'b0) begin
            n_fail++; $display("FAIL reset_overflow got %b want 0000", {ovf_a, ovf_b, ovf_c, ovf_d});
        end
        n_checks++;
        if (count_a !== 16'd0 || count_d !== 6'd0) begin
            n_fail++; $display("FAIL reset_count got %0d/%0d want 0/0", count_a, count_d);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_lanes_compare();
        int t_a, t_b;
        go_a = 1; start_a = 1; go_b = 1; start_b = 1;
        @(negedge clk);
        go_a = 0; go_b = 0;
        n_checks++;
        if (busy_a !== 1'b1 || busy_b !== 1'b1 || done_a !== 1'b0 || count_a !== 16'd0) begin
            n_fail++; $display("FAIL run_start busy=%b/%b done=%b count=%0d want 1/1 0 0",
                               busy_a, busy_b, done_a, count_a);
        end
        t_a = -1; t_b = -1;
        for (int c = 1; c <= 2000; c++) begin
            @(negedge clk);
            if (done_a && t_a < 0) t_a = c;
            if (done_b && t_b < 0) t_b = c;
            if (t_a >= 0 && t_b >= 0) break;
        end
        n_checks++;
        if (t_a < 0 || t_a > 200) begin
            n_fail++; $display("FAIL lanes4_done_time got %0d want 1..200", t_a);
        end
        n_checks++;
        if (t_b < 0) begin
            n_fail++; $display("FAIL lanes1_done_time got timeout want done");
        end
        n_checks++;
        if (!(t_a < t_b)) begin
            n_fail++; $display("FAIL lanes_speedup got lanes4=%0d lanes1=%0d want lanes4 < lanes1", t_a, t_b);
        end
        n_checks++;
        if (ovf_a !== 1'b0 || ovf_b !== 1'b0) begin
            n_fail++; $display("FAIL range1_overflow got %b/%b want 0/0", ovf_a, ovf_b);
        end
        for (int i = 0; i < 16; i++) begin
            rd_a = 4'(i); rd_b = 4'(i);
            @(negedge clk);
            n_checks++;
            if (count_a !== 16'(exp_tab[i])) begin
                n_fail++; $display("FAIL lanes4_mem[%0d] got %0d want %0d", i, count_a, exp_tab[i]);
            end
            n_checks++;
            if (count_b !== 16'(exp_tab[i])) begin
                n_fail++; $display("FAIL lanes1_mem[%0d] got %0d want %0d", i, count_b, exp_tab[i]);
            end
        end
    endtask

    task automatic test_zero_start();
        int t;
        int exp_z [4] = '{0, 1, 2, 8};
        @(negedge clk);
        go_a = 1; start_a = 0;
        @(negedge clk);
        go_a = 0;
        wait_done(0, 500, t);
        n_checks++;
        if (t < 0) begin
            n_fail++; $display("FAIL zero_done got timeout want done");
        end
        for (int i = 0; i < 4; i++) begin
            rd_a = 4'(i);
            @(negedge clk);
            n_checks++;
            if (count_a !== 16'(exp_z[i])) begin
                n_fail++; $display("FAIL zero_mem[%0d] got %0d want %0d", i, count_a, exp_z[i]);
            end
        end
    endtask

    task automatic test_overflow();
        int t;
        go_c = 1; start_c = 8'd27; rd_c = 0;
        @(negedge clk);
        go_c = 0;
        wait_done(2, 500, t);
        @(negedge clk);
        n_checks++;
        if (t < 0 || done_c !== 1'b1) begin
            n_fail++; $display("FAIL ovf_done got %b want 1", done_c);
        end
        n_checks++;
        if (ovf_c !== 1'b1) begin
            n_fail++; $display("FAIL ovf_flag got %b want 1", ovf_c);
        end
        n_checks++;
        if (count_c !== 16'hFFFF) begin
            n_fail++; $display("FAIL ovf_mem0 got %h want ffff", count_c);
        end
        rd_c = 1;
        @(negedge clk);
        n_checks++;
        if (count_c !== 16'd0) begin
            n_fail++; $display("FAIL ovf_addr_out_of_range got %0d want 0", count_c);
        end
    endtask

    task automatic test_saturate();
        int t;
        go_d = 1; start_d = 27; rd_d = 0;
        @(negedge clk);
        go_d = 0;
        wait_done(3, 500, t);
        @(negedge clk);
        n_checks++;
        if (t < 0 || count_d !== 6'd63) begin
            n_fail++; $display("FAIL sat_mem0 got %0d want 63", count_d);
        end
        n_checks++;
        if (ovf_d !== 1'b0) begin
            n_fail++; $display("FAIL sat_overflow got %b want 0", ovf_d);
        end
    endtask

    task automatic test_abort();
        int t;
        go_a = 1; start_a = 1;
        @(negedge clk);
        go_a = 0;
        repeat (5) @(negedge clk);
        go_a = 1; start_a = 100;
        @(negedge clk);
        go_a = 0;
        n_checks++;
        if (done_a !== 1'b0 || busy_a !== 1'b1) begin
            n_fail++; $display("FAIL abort_restart done=%b busy=%b want 0 1", done_a, busy_a);
        end
        wait_done(0, 500, t);
        n_checks++;
        if (t < 0) begin
            n_fail++; $display("FAIL abort_done got timeout want done");
        end
        rd_a = 0;
        @(negedge clk);
        n_checks++;
        if (count_a !== 16'd26) begin
            n_fail++; $display("FAIL abort_mem0 got %0d want 26", count_a);
        end
        rd_a = 1;
        @(negedge clk);
        n_checks++;
        if (count_a !== 16'd26) begin
            n_fail++; $display("FAIL abort_mem1 got %0d want 26", count_a);
        end
    endtask

    task automatic test_reset_mid_run();
        go_a = 1; start_a = 1;
        @(negedge clk);
        go_a = 0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0 || count_a !== 16'd0) begin
            n_fail++; $display("FAIL midrun_reset busy=%b done=%b count=%0d want 0 0 0",
                               busy_a, done_a, count_a);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy_a !== 1'b0 || done_a !== 1'b0) begin
            n_fail++; $display("FAIL after_reset_idle busy=%b done=%b want 0 0", busy_a, done_a);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_lanes_compare();
        test_zero_start();
        test_overflow();
        test_saturate();
        test_abort();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/collatz_range_multi.md
Name: collatz_range_multi

Overview:
Parametrised successor to the single-iterator Collatz range tester. Computes Collatz sequence lengths for the RAM_WORDS consecutive integers start..start+RAM_WORDS-1 using LANES parallel iterator lanes and writes each length into an internal result RAM. Adds the following, none of which the single-iterator tester has:
- width generalisation;
- overflow detection with saturation;
- a separate registered read port;
- abort-and-restart on a new go.

Parameters:
- N_WIDTH, 32, width of start value and iterator datapath.
- COUNT_WIDTH, 16, width of stored sequence length.
- RAM_WORDS, 16, number of results per run (consecutive start values).
- RAM_ADDR_BITS, 4, result address width; must satisfy 2**RAM_ADDR_BITS >= RAM_WORDS.
- LANES, 4, number of parallel collatz_lane instances, 1..RAM_WORDS.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- go  in  1  single-cycle pulse: latch start, begin a run (aborts any run in progress).
- start  in  N_WIDTH  first value of the range, sampled when go=1.
- busy  out  1  high from the cycle after go until the run completes.
- done  out  1  high once all RAM_WORDS results are written; cleared by go or reset.
- overflow  out  1  sticky: at least one lane's 3n+1 exceeded N_WIDTH during this run.
- rd_addr  in  RAM_ADDR_BITS  result index to read.
- count  out  COUNT_WIDTH  registered mem[rd_addr] when done=1, else 0.

Behaviour:
- Reset values: busy=0, done=0, overflow=0, count=0, all lanes idle, dispatch index=0. The RAM is not cleared.
- Length definition: the number of terms including n and the final 1.
  - n=1 gives 1; n=2 gives 2; n=3 gives 8.
  - n=0 gives 0, written directly without iterating.
- Lane arithmetic:
  - Even n becomes n>>1; odd n becomes 3n+1, computed at N_WIDTH+2 bits.
  - If the result does not fit in N_WIDTH, the lane stops, reports length all-ones, and sets overflow.
  - If the length reaches all-ones (2**COUNT_WIDTH-1) first, the lane stops and reports all-ones; overflow is not set.
  - Each lane performs one step per clock.
- Top-level FSM (enum in package): S_IDLE, S_RUN, S_DONE.
  - S_IDLE to S_RUN on go.
  - S_RUN to S_DONE when results written == RAM_WORDS, all lanes idle and no pending writes.
  - S_DONE to S_RUN on go.
  - go in any state: lanes are reset synchronously, pending results are discarded, overflow and done clear, busy=1 next cycle, start is re-latched and the index restarts at 0.
- Dispatch:
  - Each cycle in S_RUN, the lowest-numbered idle lane receives value base+idx and tag idx, then idx increments.
  - At most one dispatch per cycle.
  - Dispatch stops when idx == RAM_WORDS.
  - base+idx is computed modulo 2**N_WIDTH (wrap permitted).
- Write-back:
  - A finished lane holds {tag, length} with result_valid until granted.
  - One RAM write per cycle, with fixed priority to the lowest lane index.
  - A lane is re-dispatchable the cycle after its grant.
  - Simultaneous finishes are serialised, and no result is lost.
- Latency:
  - For a single value with LANES=1, the RAM write occurs length+2 cycles after dispatch.
  - done rises the cycle after the final write.
- Read port:
  - count updates one cycle after rd_addr changes.
  - count is forced to 0 while done=0.
  - rd_addr >= RAM_WORDS returns 0.
- Reset asserted mid-run returns to reset values immediately. RAM contents are then undefined-but-stale and are masked by done=0.

Decomposition:
- Package collatz_pkg:
  - state_t enum {S_IDLE, S_RUN, S_DONE};
  - lane-state enum {L_IDLE, L_ITER, L_HOLD};
  - localparam COUNT_SAT function of COUNT_WIDTH.
- Sub-module collatz_lane: go, n, tag in; busy, result_valid, result_tag, result_len, result_ovf out; grant in.
- The top level instantiates LANES copies and contains the dispatch and write arbitration, the RAM and the read register.

Test Plan:
1. Defaults, reset, then go with start=1.
   - Required: done within 200 cycles, overflow=0.
   - rd_addr 0..15 gives 1,2,8,3,6,9,17,4,20,7,15,10,10,18,18,5.
2. LANES=1 versus LANES=4, start=1.
   - Required: identical RAM contents.
   - LANES=4 finishes in strictly fewer cycles; writes from simultaneous finishes are serialised, with none missing.
3. start=0.
   - Required: mem[0]=0, mem[1]=1, mem[2]=2, mem[3]=8.
4. N_WIDTH=8, RAM_WORDS=1, start=27.
   - The step 107 to 322 overflows.
   - Required: mem[0]=0xFFFF, overflow=1, done=1.
5. COUNT_WIDTH=6, RAM_WORDS=1, start=27.
   - The true length is 112.
   - Required: saturates to 63, overflow=0.
6. go with start=1, then a second go with start=100 mid-run.
   - Required: done=0 and busy=1 the cycle after the second go.
   - Final mem[0]=26 (the length for 100), with no stale values from start=1.
   - Also: reset asserted mid-run gives busy=0, done=0 and count=0 immediately.
